// File: rtl/timer_cfg_pkg.sv
// ---------------------------------------------------------------------------
// timer_cfg_pkg
// Shared types for the timer configuration sequencer.
//   state_t   : sequencer FSM states
//   entry_t   : one sequence table entry {paddr, pwdata, mask}
//   clamp_len : limits a requested run length to the table depth
// The table stores CFG_ADDR_W / CFG_DATA_W bits per field; the sequencer
// casts these to its own bus widths, which match at the default sizes.
// ---------------------------------------------------------------------------
package timer_cfg_pkg;

   localparam int CFG_ADDR_W = 16;
   localparam int CFG_DATA_W = 32;
   localparam int IDX_W      = 3;
   localparam int LEN_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WSETUP  = 3'd1,
      ST_WACCESS = 3'd2,
      ST_RSETUP  = 3'd3,
      ST_RACCESS = 3'd4,
      ST_NEXT    = 3'd5,
      ST_FIN     = 3'd6
   } state_t;

   typedef struct packed {
      logic [CFG_ADDR_W-1:0] paddr;
      logic [CFG_DATA_W-1:0] pwdata;
      logic [CFG_DATA_W-1:0] mask;
   } entry_t;

   // Requests longer than the table are run as a full table pass.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/timer_cfg_tbl.sv
// ---------------------------------------------------------------------------
// timer_cfg_tbl
// Sequence table: register array with one synchronous write port and one
// combinational read port. Synchronous reset clears every entry.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   we, widx      : write strobe and entry index
//   wdata         : entry written on the strobe edge
//   ridx, rdata   : combinational read of one entry
// ---------------------------------------------------------------------------
module timer_cfg_tbl
   import timer_cfg_pkg::*;
#(
   parameter int N_ENTRY = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  entry_t           wdata,
   input  logic [IDX_W-1:0] ridx,
   output entry_t           rdata
);

   entry_t mem [N_ENTRY];

   // Entry storage; indices beyond the configured depth are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ENTRY; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (int'(widx) < N_ENTRY)) begin
         mem[widx] <= wdata;
      end
   end

   // Combinational read so the sequencer sees the entry in the same cycle
   // it selects it.
   always_comb begin
      rdata = '0;
      if (int'(ridx) < N_ENTRY) begin
         rdata = mem[ridx];
      end
   end

endmodule

// File: rtl/timer_cfg_seq.sv
// ---------------------------------------------------------------------------
// timer_cfg_seq
// Replays a table of register writes into a zero-wait APB timer, with an
// optional masked readback after each write.
// Ports:
//   apb_clk, apb_rst             : clock, synchronous active-high reset
//   tbl_we/idx/paddr/pwdata/mask : table write port (accepted only when idle)
//   cfg_len                      : entries to run, sampled at start, max 8
//   start, abort                 : run request, stop request
//   timx_*                       : APB master towards the timer
//   busy, done, aborted          : status; done/aborted are 1-cycle pulses
//   err, err_idx                 : sticky readback mismatch and first index
// ---------------------------------------------------------------------------
module timer_cfg_seq
   import timer_cfg_pkg::*;
#(
   parameter int N_ENTRY = 8,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32
) (
   input  logic              apb_clk,
   input  logic              apb_rst,
   input  logic              tbl_we,
   input  logic [IDX_W-1:0]  tbl_idx,
   input  logic [ADDR_W-1:0] tbl_paddr,
   input  logic [DATA_W-1:0] tbl_pwdata,
   input  logic [DATA_W-1:0] tbl_mask,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              abort,
   output logic              timx_psel,
   output logic              timx_penable,
   output logic              timx_pwrite,
   output logic [ADDR_W-1:0] timx_paddr,
   output logic [DATA_W-1:0] timx_pwdata,
   input  logic [DATA_W-1:0] timx_prdata,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              err,
   output logic [IDX_W-1:0]  err_idx
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(N_ENTRY);

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  start_len;
   logic              abort_pend;
   logic              abort_any;
   logic              start_ok;
   logic              last_entry;
   logic              rd_mismatch;
   entry_t            wr_entry;
   entry_t            cur;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [DATA_W-1:0] cur_mask;

   // A start is only honoured from IDLE; abort counts as soon as it is seen
   // in a running state, even before it has been latched.
   assign start_ok   = (state == ST_IDLE) && start;
   assign start_len  = clamp_len(cfg_len, MAX_LEN);
   assign abort_any  = abort_pend | abort;
   assign last_entry = (LEN_W'(idx) + LEN_W'(1)) >= len_q;
   assign busy       = (state != ST_IDLE);

   // Table entry currently being replayed, cast to the bus widths.
   assign cur_addr    = ADDR_W'(cur.paddr);
   assign cur_wdata   = DATA_W'(cur.pwdata);
   assign cur_mask    = DATA_W'(cur.mask);
   assign rd_mismatch = ((timx_prdata ^ cur_wdata) & cur_mask) != '0;

   // Table write data built from the loose write-port inputs.
   always_comb begin
      wr_entry        = '0;
      wr_entry.paddr  = CFG_ADDR_W'(tbl_paddr);
      wr_entry.pwdata = CFG_DATA_W'(tbl_pwdata);
      wr_entry.mask   = CFG_DATA_W'(tbl_mask);
   end

   // Writes arriving while a run is in progress are discarded so the
   // sequence being replayed cannot change underneath the FSM.
   timer_cfg_tbl #(
      .N_ENTRY (N_ENTRY)
   ) u_tbl (
      .clk   (apb_clk),
      .rst   (apb_rst),
      .we    (tbl_we && (state == ST_IDLE)),
      .widx  (tbl_idx),
      .wdata (wr_entry),
      .ridx  (idx),
      .rdata (cur)
   );

   // FSM state register.
   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and APB outputs. A SETUP phase always proceeds to its
   // ACCESS phase; an abort takes effect only once the ACCESS has completed.
   // Address and write data are held at zero whenever the bus is idle.
   always_comb begin
      state_nxt    = state;
      timx_psel    = 1'b0;
      timx_penable = 1'b0;
      timx_pwrite  = 1'b0;
      timx_paddr   = '0;
      timx_pwdata  = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (start_len == '0) ? ST_FIN : ST_WSETUP;
            end
         end
         ST_WSETUP: begin
            timx_psel   = 1'b1;
            timx_pwrite = 1'b1;
            timx_paddr  = cur_addr;
            timx_pwdata = cur_wdata;
            state_nxt   = ST_WACCESS;
         end
         ST_WACCESS: begin
            timx_psel    = 1'b1;
            timx_penable = 1'b1;
            timx_pwrite  = 1'b1;
            timx_paddr   = cur_addr;
            timx_pwdata  = cur_wdata;
            if (abort_any) begin
               state_nxt = ST_FIN;
            end else if (cur_mask != '0) begin
               state_nxt = ST_RSETUP;
            end else begin
               state_nxt = ST_NEXT;
            end
         end
         ST_RSETUP: begin
            timx_psel  = 1'b1;
            timx_paddr = cur_addr;
            state_nxt  = ST_RACCESS;
         end
         ST_RACCESS: begin
            timx_psel    = 1'b1;
            timx_penable = 1'b1;
            timx_paddr   = cur_addr;
            state_nxt    = abort_any ? ST_FIN : ST_NEXT;
         end
         ST_NEXT: begin
            if (abort_any || last_entry) begin
               state_nxt = ST_FIN;
            end else begin
               state_nxt = ST_WSETUP;
            end
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Run bookkeeping: entry index, sampled length, latched abort and the
   // sticky readback error. Only the first mismatch of a run records its
   // index; an accepted start clears the error for the new run.
   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         idx        <= '0;
         len_q      <= '0;
         abort_pend <= 1'b0;
         err        <= 1'b0;
         err_idx    <= '0;
      end else if (start_ok) begin
         idx        <= '0;
         len_q      <= start_len;
         abort_pend <= 1'b0;
         err        <= 1'b0;
         err_idx    <= '0;
      end else begin
         if (state == ST_FIN) begin
            abort_pend <= 1'b0;
         end else if (busy && abort) begin
            abort_pend <= 1'b1;
         end
         if (state == ST_NEXT) begin
            idx <= idx + IDX_W'(1);
         end
         if ((state == ST_RACCESS) && rd_mismatch && !err) begin
            err     <= 1'b1;
            err_idx <= idx;
         end
      end
   end

   // Completion pulses, raised for the single cycle after FIN.
   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         done    <= 1'b0;
         aborted <= 1'b0;
      end else begin
         done    <= (state == ST_FIN) && !abort_any;
         aborted <= (state == ST_FIN) && abort_any;
      end
   end

endmodule
